// File: rtl/seven_seg_scanner_pkg.sv
// Shared constants and helpers for the seven-segment display scanner slice.
package seven_seg_scanner_pkg;

  localparam logic [6:0] SEG_BLANK_N = 7'h7F;
  localparam int         NIB_W       = 4;

  // Width needed to hold prescaler values 0..div-1 (never narrower than 1 bit).
  function automatic int prescale_width(input int div);
    return ($clog2(div) < 1) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/seven_seg_scanner_converter.sv
// Hex nibble to active-high seven-segment code, bit order g..a.
module seven_seg_converter
  import seven_seg_scanner_pkg::*;
(
  input  logic [NIB_W-1:0] nibble,
  output logic [6:0]       seg
);

  // Glyph lookup for 0-9 and A-F.
  always_comb begin
    seg = 7'h00;
    case (nibble)
      4'h0:    seg = 7'h3F;
      4'h1:    seg = 7'h06;
      4'h2:    seg = 7'h5B;
      4'h3:    seg = 7'h4F;
      4'h4:    seg = 7'h66;
      4'h5:    seg = 7'h6D;
      4'h6:    seg = 7'h7D;
      4'h7:    seg = 7'h07;
      4'h8:    seg = 7'h7F;
      4'h9:    seg = 7'h6F;
      4'hA:    seg = 7'h77;
      4'hB:    seg = 7'h7C;
      4'hC:    seg = 7'h39;
      4'hD:    seg = 7'h5E;
      4'hE:    seg = 7'h79;
      4'hF:    seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode seven-segment driver with frame-synchronous
// double-buffered value updates and optional leading-zero blanking.
module seven_seg_scanner
  import seven_seg_scanner_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NIB_W*NUM_DIGITS-1:0] value,
  input  logic                        load,
  input  logic                        blank_lz,
  input  logic [NUM_DIGITS-1:0]       dp_mask,
  output logic [6:0]                  seg_n,
  output logic                        dp_n,
  output logic [NUM_DIGITS-1:0]       an_n,
  output logic                        frame_done
);

  localparam int              PW       = prescale_width(REFRESH_DIV);
  localparam int              DW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int              VW       = NIB_W * NUM_DIGITS;
  localparam logic [PW-1:0]   PRE_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0]   DIG_LAST = DW'(NUM_DIGITS - 1);

  logic [PW-1:0]         prescaler_r;
  logic [DW-1:0]         digit_r;
  logic [VW-1:0]         pending_r;
  logic [VW-1:0]         disp_r;
  logic [6:0]            seg_n_r;
  logic                  dp_n_r;
  logic [NUM_DIGITS-1:0] an_n_r;
  logic                  frame_done_r;

  logic                  tick_s;
  logic                  commit_s;
  logic                  blank_s;
  logic [NIB_W-1:0]      nibble_s;
  logic [6:0]            seg_code_s;
  logic [6:0]            seg_next_s;
  logic                  dp_next_s;
  logic [NUM_DIGITS-1:0] an_next_s;
  logic [NUM_DIGITS-1:0] lz_zero_s;

  // Slot end and frame end (commit point) decode.
  always_comb begin
    tick_s   = (prescaler_r == PRE_LAST);
    commit_s = tick_s && (digit_r == DIG_LAST);
  end

  // lz_zero_s[i] is set when nibbles i..NUM_DIGITS-1 of the shown value are all zero.
  always_comb begin
    logic zero_run;
    zero_run  = 1'b1;
    lz_zero_s = {NUM_DIGITS{1'b0}};
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run     = zero_run && (disp_r[NIB_W*i +: NIB_W] == 4'h0);
      lz_zero_s[i] = zero_run;
    end
  end

  // Nibble of the digit currently being scanned; digit 0 is never blanked.
  always_comb begin
    nibble_s = disp_r[NIB_W*int'(digit_r) +: NIB_W];
    blank_s  = blank_lz && (digit_r != {DW{1'b0}}) && lz_zero_s[digit_r];
  end

  seven_seg_converter u_conv (
    .nibble (nibble_s),
    .seg    (seg_code_s)
  );

  // Pin values for the next cycle; the first cycle of each slot is dark to stop ghosting.
  always_comb begin
    an_next_s  = {NUM_DIGITS{1'b1}};
    seg_next_s = SEG_BLANK_N;
    dp_next_s  = 1'b1;
    if ((prescaler_r == {PW{1'b0}}) || blank_s) begin
      an_next_s  = {NUM_DIGITS{1'b1}};
      seg_next_s = SEG_BLANK_N;
      dp_next_s  = 1'b1;
    end else begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        an_next_s[i] = (DW'(i) != digit_r);
      end
      seg_next_s = ~seg_code_s;
      dp_next_s  = ~dp_mask[digit_r];
    end
  end

  // Refresh prescaler and digit scan counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prescaler_r <= {PW{1'b0}};
      digit_r     <= {DW{1'b0}};
    end else if (tick_s) begin
      prescaler_r <= {PW{1'b0}};
      digit_r     <= (digit_r == DIG_LAST) ? {DW{1'b0}} : digit_r + DW'(1);
    end else begin
      prescaler_r <= prescaler_r + PW'(1);
    end
  end

  // Double buffer: a load landing on the commit edge goes straight to the display.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_r <= {VW{1'b0}};
      disp_r    <= {VW{1'b0}};
    end else begin
      if (load) begin
        pending_r <= value;
      end
      if (commit_s) begin
        disp_r <= load ? value : pending_r;
      end
    end
  end

  // Registered pin drivers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_n_r      <= SEG_BLANK_N;
      dp_n_r       <= 1'b1;
      an_n_r       <= {NUM_DIGITS{1'b1}};
      frame_done_r <= 1'b0;
    end else begin
      seg_n_r      <= seg_next_s;
      dp_n_r       <= dp_next_s;
      an_n_r       <= an_next_s;
      frame_done_r <= commit_s;
    end
  end

  assign seg_n      = seg_n_r;
  assign dp_n       = dp_n_r;
  assign an_n       = an_n_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner with REFRESH_DIV=4, NUM_DIGITS=4.
module tb_seven_seg_scanner;

  localparam int ND = 4;
  localparam int RD = 4;

  logic          clk;
  logic          rst_n;
  logic [15:0]   value;
  logic          load;
  logic          blank_lz;
  logic [3:0]    dp_mask;
  logic [6:0]    seg_n;
  logic          dp_n;
  logic [3:0]    an_n;
  logic          frame_done;

  seven_seg_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(RD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .load       (load),
    .blank_lz   (blank_lz),
    .dp_mask    (dp_mask),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] value;
    logic        blz;
    logic [3:0]  dpm;
    logic [3:0]  lit;   // digits expected to light up
  } vec_t;

  typedef struct {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       fd;
  } exp_t;

  exp_t sb_q[$];
  vec_t tbl[7];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [6:0] hex2seg(input logic [3:0] h);
    case (h)
      4'h0: return 7'b0111111;
      4'h1: return 7'b0000110;
      4'h2: return 7'b1011011;
      4'h3: return 7'b1001111;
      4'h4: return 7'b1100110;
      4'h5: return 7'b1101101;
      4'h6: return 7'b1111101;
      4'h7: return 7'b0000111;
      4'h8: return 7'b1111111;
      4'h9: return 7'b1101111;
      4'hA: return 7'b1110111;
      4'hB: return 7'b1111100;
      4'hC: return 7'b0111001;
      4'hD: return 7'b1011110;
      4'hE: return 7'b1111001;
      default: return 7'b1110001;
    endcase
  endfunction

  task automatic push_blank();
    exp_t e;
    e.seg = 7'h7F; e.dp = 1'b1; e.an = 4'hF; e.fd = 1'b0;
    sb_q.push_back(e);
  endtask

  // Expected pins for whole frames, starting on the dark cycle of digit 0.
  task automatic push_frame(input logic [15:0] v, input logic [3:0] dpm,
                            input logic [3:0] lit, input int nframes);
    exp_t e;
    for (int f = 0; f < nframes; f++) begin
      for (int k = 0; k < 16; k++) begin
        int slot;
        slot = k / 4;
        e.seg = 7'h7F; e.dp = 1'b1; e.an = 4'hF; e.fd = (k == 15);
        if ((k % 4) != 0 && lit[slot]) begin
          e.an[slot] = 1'b0;
          e.seg      = ~hex2seg(v[4*slot +: 4]);
          e.dp       = ~dpm[slot];
        end
        sb_q.push_back(e);
      end
    end
  endtask

  task automatic check_cycle(input string tag);
    exp_t e;
    @(negedge clk);
    n_vec++;
    if (sb_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s: no expected entry queued", tag);
    end else begin
      e = sb_q.pop_front();
      if ({seg_n, dp_n, an_n, frame_done} !== {e.seg, e.dp, e.an, e.fd}) begin
        n_bad++;
        $display("FAIL %s @%0t: got seg_n=%h dp_n=%b an_n=%h frame_done=%b, want seg_n=%h dp_n=%b an_n=%h frame_done=%b",
                 tag, $time, seg_n, dp_n, an_n, frame_done, e.seg, e.dp, e.an, e.fd);
      end
    end
  endtask

  task automatic drain(input string tag);
    while (sb_q.size() > 0) check_cycle(tag);
  endtask

  task automatic do_load(input logic [15:0] v);
    load  = 1'b1;
    value = v;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic wait_fd(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (!seen) begin
        @(negedge clk);
        seen = (frame_done === 1'b1);
      end
    end
    if (!seen) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s: frame_done timeout, got 0 want 1 within 64 cycles", tag);
    end
  endtask

  initial begin
    tbl[0] = '{16'h1234, 1'b0, 4'b0000, 4'b1111};
    tbl[1] = '{16'h00A5, 1'b1, 4'b0010, 4'b0011};
    tbl[2] = '{16'h0000, 1'b1, 4'b0001, 4'b0001};
    tbl[3] = '{16'h0F00, 1'b1, 4'b1000, 4'b0111};
    tbl[4] = '{16'h0000, 1'b0, 4'b0000, 4'b1111};
    tbl[5] = '{16'hFEDC, 1'b1, 4'b0101, 4'b1111};
    tbl[6] = '{16'h0001, 1'b1, 4'b1111, 4'b0001};

    rst_n = 1'b0; load = 1'b1; value = 16'h1234; blank_lz = 1'b0; dp_mask = 4'h0;

    // Reset held with a load pending; display must come up showing 0.
    repeat (3) push_blank();
    repeat (3) check_cycle("reset");
    rst_n = 1'b1;
    load  = 1'b0;
    push_frame(16'h0000, 4'h0, 4'b1111, 2);
    drain("post_reset");

    foreach (tbl[i]) begin
      blank_lz = tbl[i].blz;
      dp_mask  = tbl[i].dpm;
      do_load(tbl[i].value);
      wait_fd("table");
      push_frame(tbl[i].value, tbl[i].dpm, tbl[i].lit, 2);
      drain("table");
    end

    // Mid-frame load must not tear the frame being shown.
    blank_lz = 1'b0;
    dp_mask  = 4'h0;
    do_load(16'h1234);
    wait_fd("dbuf");
    push_frame(16'h1234, 4'h0, 4'b1111, 1);
    for (int k = 0; k < 16; k++) begin
      check_cycle("dbuf_old");
      if (k == 5) begin load = 1'b1; value = 16'hABCD; end
      if (k == 6) load = 1'b0;
    end

    // Load on the commit edge overrides the earlier pending value.
    push_frame(16'hABCD, 4'h0, 4'b1111, 1);
    for (int k = 0; k < 16; k++) begin
      check_cycle("dbuf_new");
      if (k == 2)  begin load = 1'b1; value = 16'h5555; end
      if (k == 3)  load = 1'b0;
      if (k == 14) begin load = 1'b1; value = 16'h00F0; end
      if (k == 15) load = 1'b0;
    end

    // Reset during digit 2 restarts the scan from digit 0 with a cleared value.
    push_frame(16'h00F0, 4'h0, 4'b1111, 1);
    for (int k = 0; k < 10; k++) check_cycle("simul");
    rst_n    = 1'b0;
    blank_lz = 1'b1;
    sb_q.delete();
    push_blank();
    check_cycle("rst_mid");
    rst_n = 1'b1;
    push_frame(16'h0000, 4'h0, 4'b0001, 2);
    drain("rst_restart");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
